// File: rtl/simon_if.sv
// Bundles the user-facing switch/button inputs and display/status outputs of the Simon sequencer.
interface simon_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int LIVES = 1
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LIVES + 1);

  logic [WIDTH-1:0] pattern;
  logic             pattern_valid;
  logic             step;
  logic [WIDTH-1:0] display_pattern;
  logic [2:0]       mode_leds;
  logic [AW:0]      level;
  logic [AW-1:0]    index;
  logic [LW-1:0]    lives_left;

  modport master (
    output pattern, pattern_valid, step,
    input  display_pattern, mode_leds, level, index, lives_left
  );

  modport slave (
    input  pattern, pattern_valid, step,
    output display_pattern, mode_leds, level, index, lives_left
  );
endinterface

// File: rtl/simon_sequencer.sv
// Simon-style memory game: user enters a growing pattern sequence, watches it replayed,
// then repeats it back; mismatches cost lives, filling the store wins.
module simon_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int LIVES = 1,
  parameter int DWELL = 1
) (
  input  logic     clk,
  input  logic     rst,
  simon_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LIVES + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    S_INPUT = 3'b001,
    S_PLAY  = 3'b010,
    S_REP   = 3'b100,
    S_DONE  = 3'b111,
    S_WIN   = 3'b011
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_level;
  logic [AW-1:0]    r_index;
  logic [DW-1:0]    r_dwell;
  logic [LW-1:0]    r_lives;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_rd;
  logic             w_accept, w_dwell_last, w_idx_last, w_match, w_lives_more, w_full;
  logic [2:0]       w_mode;
  logic [WIDTH-1:0] w_disp;

  // Index is always below level in the states that read the store.
  assign w_rd         = r_mem[r_index];
  assign w_full       = (r_level == (AW+1)'(DEPTH));
  assign w_accept     = bus.step && bus.pattern_valid && !w_full;
  assign w_dwell_last = (r_dwell == DW'(DWELL - 1));
  assign w_idx_last   = ({1'b0, r_index} == (r_level - (AW+1)'(1)));
  assign w_match      = (bus.pattern == w_rd);
  assign w_lives_more = (r_lives > LW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INPUT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INPUT: if (w_accept) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_dwell_last && w_idx_last) w_state_nxt = S_REP;
      S_REP: begin
        if (bus.step) begin
          if (w_match) begin
            if (w_idx_last) w_state_nxt = w_full ? S_WIN : S_INPUT;
          end else begin
            w_state_nxt = w_lives_more ? S_PLAY : S_DONE;
          end
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Output decode from state register only
  always_comb begin
    w_mode = 3'b001;
    w_disp = bus.pattern;
    case (r_state)
      S_INPUT: begin w_mode = 3'b001; w_disp = bus.pattern; end
      S_PLAY:  begin w_mode = 3'b010; w_disp = w_rd;        end
      S_REP:   begin w_mode = 3'b100; w_disp = bus.pattern; end
      S_DONE:  begin w_mode = 3'b111; w_disp = w_rd;        end
      S_WIN:   begin w_mode = 3'b011; w_disp = w_rd;        end
      default: begin w_mode = 3'b001; w_disp = bus.pattern; end
    endcase
  end

  // Counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_index <= '0;
      r_dwell <= '0;
      r_lives <= LW'(LIVES);
    end else begin
      case (r_state)
        S_INPUT: begin
          if (w_accept) begin
            r_level <= r_level + (AW+1)'(1);
            r_index <= '0;
            r_dwell <= '0;
          end
        end
        S_PLAY: begin
          if (w_dwell_last) begin
            r_dwell <= '0;
            r_index <= w_idx_last ? '0 : r_index + AW'(1);
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        S_REP: begin
          if (bus.step) begin
            if (w_match) begin
              r_index <= w_idx_last ? '0 : r_index + AW'(1);
            end else if (w_lives_more) begin
              r_lives <= r_lives - LW'(1);
              r_index <= '0;
              r_dwell <= '0;
            end else begin
              r_lives <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pattern store: not reset, written only on an accepted entry
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_INPUT && w_accept)
      r_mem[r_level[AW-1:0]] <= bus.pattern;
  end

  assign bus.display_pattern = w_disp;
  assign bus.mode_leds       = w_mode;
  assign bus.level           = r_level;
  assign bus.index           = r_index;
  assign bus.lives_left      = r_lives;
endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, bit width of one pattern; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 16, maximum sequence length and entries of internal pattern store; SHALL be >= 2.
REQ-003 Parameter LIVES, default 1, mismatches tolerated before game over; SHALL be >= 1.
REQ-004 Parameter DWELL, default 1, clock cycles each stored pattern is shown during playback; SHALL be >= 1.
REQ-005 Derived: AW = clog2(DEPTH); LW = clog2(LIVES+1).
REQ-006 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 Port rst, input, 1, reset, synchronous and active-high.
REQ-008 Port pattern, input, WIDTH, user switch pattern.
REQ-009 Port pattern_valid, input, 1, pattern is legal for entry; examined only in INPUT.
REQ-010 Port step, input, 1, one-cycle user advance strobe (debounced button).
REQ-011 Port display_pattern, output, WIDTH, pattern to drive display.
REQ-012 Port mode_leds, output, 3, state indicator.
REQ-013 Port level, output, AW+1, number of stored patterns (0..DEPTH).
REQ-014 Port index, output, AW, current playback/repeat position.
REQ-015 Port lives_left, output, LW, remaining lives.

Function
REQ-016 States and mode_leds encodings: INPUT 3'b001, PLAYBACK 3'b010, REPEAT 3'b100, DONE 3'b111, WIN 3'b011; mode_leds SHALL decode from the state register only.
REQ-017 Internal store DEPTH x WIDTH; written only in INPUT; contents not reset; never read at address >= level.
REQ-018 display_pattern SHALL equal pattern in INPUT and REPEAT, store[index] in PLAYBACK, DONE and WIN (combinational, same cycle).
REQ-019 INPUT, step && pattern_valid: store[level] <= pattern, level <= level+1, index <= 0, dwell <= 0, next PLAYBACK.
REQ-020 INPUT, step && !pattern_valid: no write, no state change; INPUT without step: hold.
REQ-021 PLAYBACK: dwell counter increments each cycle; at dwell == DWELL-1, dwell <= 0 and index advances; at index == level-1 instead index <= 0, next REPEAT; each entry shown exactly DWELL cycles.
REQ-022 PLAYBACK SHALL ignore step and pattern_valid.
REQ-023 REPEAT, step && pattern == store[index] && index < level-1: index <= index+1.
REQ-024 REPEAT, step && match && index == level-1: index <= 0; next WIN if level == DEPTH, else INPUT.
REQ-025 REPEAT, step && mismatch && lives_left > 1: lives_left decrements, index <= 0, dwell <= 0, next PLAYBACK (full replay).
REQ-026 REPEAT, step && mismatch && lives_left == 1: lives_left <= 0, next DONE.
REQ-027 DONE and WIN are terminal: step and pattern_valid ignored; only rst exits.
REQ-028 level SHALL never exceed DEPTH; INPUT is unreachable with level == DEPTH.
REQ-029 Counters SHALL be unsigned; index and dwell SHALL never wrap past their limits.

Reset
REQ-030 rst sampled high at a rising edge: state INPUT, level 0, index 0, dwell 0, lives_left LIVES on the following cycle.
REQ-031 rst SHALL take priority over step, pattern_valid and all state transitions in that cycle, from any state including mid-playback.
REQ-032 After reset mode_leds = 3'b001 and display_pattern = pattern.

Verification (WIDTH=4, DEPTH=4, LIVES=2, DWELL=2 unless stated)
REQ-033 rst 1 cycle -> mode_leds 001, level 0, index 0, lives_left 2; step with pattern_valid=0, pattern 4'h5 -> still 001, level 0.
REQ-034 INPUT, pattern 4'h5, pattern_valid=1, step -> mode_leds 010, level 1, display 4'h5 for exactly 2 cycles, then 100; step asserted during playback has no effect.
REQ-035 REPEAT, pattern 4'h5, step -> 001, level 1; enter 4'hA -> playback 5,5,A,A then 100; enter 5 then A -> 001, level 2.
REQ-036 REPEAT mismatch (enter 4'h3 vs 4'h5) -> lives_left 1, 010, playback from index 0; second mismatch -> 111, lives_left 0; further steps hold 111; rst -> 001, lives_left 2.
REQ-037 Fill to level 4 with all repeats correct -> final correct step gives 011 (WIN), level 4, holds under step.
REQ-038 rst asserted together with step in REPEAT at index 1 -> next cycle 001, level 0, index 0; DWELL=1 variant shows one cycle per entry.
